spw_ulight_nofifo_monitor_ctrl: RTL and testbench

SPW_ULIGHT_NOFIFO_MONITOR_CTRL -- requirements
Module: spw_ulight_nofifo_monitor_ctrl

---
 rtl/spw_ulight_nofifo_monitor_ctrl_if.sv | 12 +
 rtl/spw_ulight_nofifo_monitor_ctrl.sv | 64 ++++++
 tb/tb_spw_ulight_nofifo_monitor_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spw_ulight_nofifo_monitor_ctrl_if.sv
// spw_ulight_nofifo_monitor_ctrl_if: Avalon-MM slave bus plus level irq towards the Nios II
// master drives address/chipselect/write_n/writedata, slave returns readdata/irq
interface spw_ulight_nofifo_monitor_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/spw_ulight_nofifo_monitor_ctrl.sv
// spw_ulight_nofifo_monitor_ctrl: synchronizes SpaceWire link status, captures edges, counts change cycles, raises irq
// clk/reset: sole clock, async active-high reset; in_port: raw status (async); bus: Avalon-MM slave + irq
// map: 0 DATA (RO), 1 IRQMASK (RW), 2 EDGECAP (W1C), 3 CHGCNT (any write clears)
module spw_ulight_nofifo_monitor_ctrl #(
  parameter int WIDTH = 14,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_port,
  spw_ulight_nofifo_monitor_ctrl_if.slave bus
);
  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [WIDTH-1:0] mask_q, mask_d, ecap_q, ecap_d, chg, clr;
  logic [1:0]       prime_q, prime_d;
  logic             armed_q, armed_d, wr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_wdata;
  assign unused_wdata = ^bus.writedata[31:WIDTH];
  assign bus.readdata = rdata_q;
  assign bus.irq = |(ecap_q & mask_q);
  always_comb begin
    wr = bus.chipselect & ~bus.write_n;
    s1_d = in_port;
    s2_d = s1_q;
    s3_d = s2_q;
    prime_d = (&prime_q) ? prime_q : prime_q + 2'd1;
    // arm on the third clock after release so the synchronizer fill is never seen as a change
    armed_d = armed_q | (&prime_d);
    chg = (s2_q ^ s3_q) & {WIDTH{armed_q}};
    clr = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
    mask_d = (wr && bus.address == 2'd1) ? bus.writedata[WIDTH-1:0] : mask_q;
    ecap_d = (ecap_q & ~clr) | chg;
    cnt_d = (wr && bus.address == 2'd3) ? CNT_W'(|chg) :
            (|chg && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    rdata_d = bus.address == 2'd0 ? 32'(s2_q) :
              bus.address == 2'd1 ? 32'(mask_q) :
              bus.address == 2'd2 ? 32'(ecap_q) : 32'(cnt_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      prime_q <= '0;
      armed_q <= 1'b0;
      mask_q <= '0;
      ecap_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      prime_q <= prime_d;
      armed_q <= armed_d;
      mask_q <= mask_d;
      ecap_q <= ecap_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_spw_ulight_nofifo_monitor_ctrl.sv
// tb_spw_ulight_nofifo_monitor_ctrl: randomized scoreboard bench against a history-based reference model
module tb_spw_ulight_nofifo_monitor_ctrl;
  localparam int W = 14;
  logic clk = 0, reset = 1;
  logic [W-1:0] in_port = '0;
  spw_ulight_nofifo_monitor_ctrl_if bus();
  spw_ulight_nofifo_monitor_ctrl #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus.slave));
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  logic [31:0] rq[$];
  logic iq[$];
  int n = 0;
  logic [W-1:0] h1 = '0, h2 = '0, h3 = '0, m_mask = '0, m_ecap = '0;
  logic [15:0] m_cnt = '0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // reference: h1/h2/h3 are in_port as applied 1/2/3 edges back; a change is
  // visible at edge n when the values from 2 and 3 edges back differ, from the 4th edge on
  always @(posedge clk or posedge reset) begin
    logic [W-1:0] chg;
    logic [31:0] rd;
    logic wr;
    if (reset) begin
      n = 0; h1 = '0; h2 = '0; h3 = '0;
      m_mask = '0; m_ecap = '0; m_cnt = '0;
      rq.delete(); iq.delete();
    end else begin
      n++;
      case (bus.address)
        2'd0: rd = 32'(h2);
        2'd1: rd = 32'(m_mask);
        2'd2: rd = 32'(m_ecap);
        default: rd = 32'(m_cnt);
      endcase
      chg = (n >= 4) ? (h2 ^ h3) : '0;
      wr = bus.chipselect && !bus.write_n;
      if (wr && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
      m_ecap = (m_ecap & ~((wr && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0)) | chg;
      if (wr && bus.address == 2'd3) m_cnt = (chg != 0) ? 16'd1 : 16'd0;
      else if (chg != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      h3 = h2; h2 = h1; h1 = in_port;
      if (bus.chipselect && bus.write_n) rq.push_back(rd);
      iq.push_back(|(m_ecap & m_mask));
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (rq.size() != 0) chk("readdata", bus.readdata, rq.pop_front());
      if (iq.size() != 0) chk("irq", {31'b0, bus.irq}, {31'b0, iq.pop_front()});
    end
  end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1; bus.write_n = 0;
    cycle();
    bus.chipselect = 0; bus.write_n = 1;
  endtask
  task automatic rd(input logic [1:0] a);
    bus.address = a; bus.chipselect = 1; bus.write_n = 1;
    cycle();
    bus.chipselect = 0;
  endtask
  initial begin
    bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
    in_port = 14'h0005;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", {31'b0, bus.irq}, 32'h0);
    reset = 0;
    repeat (10) cycle();
    rd(0); rd(2); rd(3); rd(1);
    wr(1, 32'h2);
    in_port ^= 14'h0002;
    repeat (4) cycle();
    rd(2); rd(3);
    wr(2, 32'h2);
    repeat (2) cycle();
    in_port ^= 14'h0009;
    repeat (4) cycle();
    rd(2); rd(3);
    wr(2, 32'h3FFF);
    cycle();
    in_port ^= 14'h0001;
    repeat (2) cycle();
    wr(2, 32'h1);
    rd(2);
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) in_port ^= W'($urandom);
      case ($urandom_range(0, 3))
        0: rd(2'($urandom));
        1: wr(2'($urandom), $urandom);
        default: cycle();
      endcase
    end
    repeat (4) cycle();
    wr(3, 32'h0);
    repeat (16'hFFFE) begin
      in_port ^= 14'h0001;
      cycle();
    end
    repeat (3) cycle();
    rd(3);
    repeat (4) begin
      in_port ^= 14'h0001;
      cycle();
    end
    repeat (3) cycle();
    rd(3);
    in_port ^= 14'h0001;
    repeat (2) cycle();
    wr(3, 32'h0);
    rd(3);
    wr(1, 32'h3FFF);
    wr(3, 32'h0);
    repeat (5) begin
      in_port ^= 14'h0002;
      repeat (2) cycle();
    end
    repeat (3) cycle();
    rd(3);
    bus.address = 2'd3;
    #2;
    reset = 1;
    #1;
    chk("async_readdata", bus.readdata, 32'h0);
    chk("async_irq", {31'b0, bus.irq}, 32'h0);
    in_port = '0;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (5) cycle();
    rd(0); rd(1); rd(2); rd(3);
    repeat (2) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
